// File: rtl/sram_test_pkg.sv
// rtl/sram_test_pkg.sv - shared types, constants and pattern function for the SRAM tester
package sram_test_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        PASS_END,
        DONE
    } state_t;

    // Callers truncate to their data width; inversion on odd seeds covers both polarities per bit.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
        logic [31:0] x;
        x = addr ^ seed;
        return seed[0] ? ~x : x;
    endfunction

endpackage

// File: rtl/sram_tester_chk.sv
// rtl/sram_tester_chk.sv - read-data compare, saturating error counter and first-error capture
module sram_tester_chk
    import sram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] got_data,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else if (valid && (exp_data != got_data)) begin
            if (err_count == '0) begin
                first_err_addr <= addr;
                first_err_exp  <= exp_data;
                first_err_got  <= got_data;
            end
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_tester.sv
// rtl/sram_tester.sv - write/read-back pattern generator and checker for the SRAM controller
module sram_tester
    import sram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_LAST  = 2**19-1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loop,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic [CNT_W-1:0]      pass_count,
    output logic                  sram_req,
    input  logic                  sram_ack,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_rh_wl,
    output logic [DATA_WIDTH-1:0] sram_data_w,
    input  logic [DATA_WIDTH-1:0] sram_data_r,
    input  logic                  sram_data_r_en
);

    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(ADDR_LAST);
    localparam int                    WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  stop_q, stop_d;
    logic                  req_q, req_d;
    logic                  rh_wl_q, rh_wl_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      pass_q, pass_d;
    logic                  cmp_valid;
    logic                  clear;
    logic [31:0]           pat_full;
    logic [DATA_WIDTH-1:0] cur_pat;

    assign pat_full = pat(32'(addr_q), 32'(seed_q));
    assign cur_pat  = pat_full[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            seed_q    <= '0;
            wd_q      <= '0;
            stop_q    <= 1'b0;
            req_q     <= 1'b0;
            rh_wl_q   <= 1'b0;
            data_w_q  <= '0;
            timeout_q <= 1'b0;
            pass_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            wd_q      <= wd_d;
            stop_q    <= stop_d;
            req_q     <= req_d;
            rh_wl_q   <= rh_wl_d;
            data_w_q  <= data_w_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        seed_d    = seed_q;
        wd_d      = wd_q;
        stop_d    = stop_q | (stop & busy);
        req_d     = req_q;
        rh_wl_d   = rh_wl_q;
        data_w_d  = data_w_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        cmp_valid = 1'b0;
        clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR_REQ;
                    addr_d    = '0;
                    seed_d    = '0;
                    wd_d      = '0;
                    stop_d    = 1'b0;
                    timeout_d = 1'b0;
                    pass_d    = '0;
                    clear     = 1'b1;
                end
            end
            WR_REQ, RD_REQ: begin
                if (req_q && sram_ack) begin
                    req_d = 1'b0;
                    wd_d  = '0;
                    if (state_q == WR_REQ) begin
                        if (addr_q == LAST) begin
                            addr_d  = '0;
                            state_d = RD_REQ;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (sram_data_r_en) begin
                        cmp_valid = 1'b1;
                        if (addr_q == LAST) state_d = PASS_END;
                        else                addr_d  = addr_q + 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    // Raising req here guarantees one idle cycle after every ack.
                    if (!req_q) begin
                        req_d    = 1'b1;
                        rh_wl_d  = (state_q == RD_REQ);
                        data_w_d = cur_pat;
                    end
                end
            end
            RD_WAIT: begin
                if (sram_data_r_en) begin
                    cmp_valid = 1'b1;
                    wd_d      = '0;
                    if (addr_q == LAST) begin
                        state_d = PASS_END;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            PASS_END: begin
                pass_d = pass_q + 1'b1;
                seed_d = seed_q + 1'b1;
                wd_d   = '0;
                addr_d = '0;
                if (loop && !(stop_q || stop)) state_d = WR_REQ;
                else                           state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign timeout     = timeout_q;
    assign pass_count  = pass_q;
    assign sram_req    = req_q;
    assign sram_addr   = addr_q;
    assign sram_rh_wl  = rh_wl_q;
    assign sram_data_w = data_w_q;

    sram_tester_chk #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .valid         (cmp_valid),
        .addr          (addr_q),
        .exp_data      (cur_pat),
        .got_data      (sram_data_r),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

endmodule

// File: tb/tb_sram_tester.sv
// tb/tb_sram_tester.sv - scoreboard bench for sram_tester against a behavioural SRAM model
module tb_sram_tester;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int LAST = 15;
    localparam int TO   = 255;

    logic          clk = 1'b0;
    logic          reset, start, loop, stop;
    logic          busy, done, timeout;
    logic [15:0]   err_count, pass_count;
    logic [AW-1:0] first_err_addr, sram_addr;
    logic [DW-1:0] first_err_exp, first_err_got, sram_data_w, sram_data_r;
    logic          sram_req, sram_ack, sram_rh_wl, sram_data_r_en;

    sram_tester #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ADDR_LAST (LAST),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .loop          (loop),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got),
        .pass_count    (pass_count),
        .sram_req      (sram_req),
        .sram_ack      (sram_ack),
        .sram_addr     (sram_addr),
        .sram_rh_wl    (sram_rh_wl),
        .sram_data_w   (sram_data_w),
        .sram_data_r   (sram_data_r),
        .sram_data_r_en(sram_data_r_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_pat(input int a, input int s);
        logic [7:0] x;
        x = a[7:0] ^ s[7:0];
        return s[0] ? ~x : x;
    endfunction

    // Behavioural SRAM: configurable ack delay and read latency, optional stuck bit at addr 5.
    bit          rand_mode = 0;
    bit          never_ack = 0;
    bit          fault_en  = 0;
    bit          model_rst = 0;
    logic [7:0]  mem [16];
    logic [11:0] wq[$];
    logic [3:0]  rq[$];
    int          wr_seen = 0;
    int          rd_seen = 0;
    bit          in_req  = 0;
    bit          stable;
    int          dly;
    int          rd_pend = 0;
    int          lat;
    logic [3:0]  cap_addr;
    logic        cap_rw;
    logic [7:0]  cap_d;
    logic [7:0]  rd_val;
    logic [11:0] ent;
    logic [3:0]  ra;

    initial begin
        sram_ack       = 1'b0;
        sram_data_r_en = 1'b0;
        sram_data_r    = '0;
        forever begin
            @(negedge clk);
            sram_ack       = 1'b0;
            sram_data_r_en = 1'b0;
            if (model_rst) begin
                in_req  = 0;
                rd_pend = 0;
            end else begin
                if (rd_pend > 0) begin
                    rd_pend--;
                    if (rd_pend == 0) begin
                        sram_data_r_en = 1'b1;
                        sram_data_r    = rd_val;
                    end
                end
                if (sram_req && !never_ack) begin
                    if (!in_req) begin
                        check("no_overlap", rd_pend, 0);
                        in_req   = 1;
                        stable   = 1;
                        dly      = rand_mode ? int'($urandom_range(0, 10)) : 0;
                        cap_addr = sram_addr;
                        cap_rw   = sram_rh_wl;
                        cap_d    = sram_data_w;
                    end else if (sram_addr !== cap_addr || sram_rh_wl !== cap_rw || sram_data_w !== cap_d) begin
                        stable = 0;
                    end
                    if (dly == 0) begin
                        sram_ack = 1'b1;
                        in_req   = 0;
                        check("req_stable", 32'(stable), 1);
                        if (!cap_rw) begin
                            wr_seen++;
                            mem[cap_addr] = cap_d;
                            if (wq.size() == 0) begin
                                check("wr_extra", 1, 0);
                            end else begin
                                ent = wq.pop_front();
                                check("wr_addr", 32'(cap_addr), 32'(ent[11:8]));
                                check("wr_data", 32'(cap_d), 32'(ent[7:0]));
                            end
                        end else begin
                            rd_seen++;
                            if (rq.size() == 0) begin
                                check("rd_extra", 1, 0);
                            end else begin
                                ra = rq.pop_front();
                                check("rd_addr", 32'(cap_addr), 32'(ra));
                            end
                            rd_val = mem[cap_addr] | ((fault_en && cap_addr == 4'd5) ? 8'h08 : 8'h00);
                            lat    = rand_mode ? int'($urandom_range(0, 2)) : 2;
                            if (lat == 0) begin
                                sram_data_r_en = 1'b1;
                                sram_data_r    = rd_val;
                            end else begin
                                rd_pend = lat;
                            end
                        end
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    task automatic push_pass(input int s);
        for (int a = 0; a <= LAST; a++) begin
            wq.push_back({4'(a), tb_pat(a, s)});
            rq.push_back(4'(a));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        model_rst = 1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_rst = 0;
        in_req    = 0;
        rd_pend   = 0;
        wq.delete();
        rq.delete();
    endtask

    task automatic do_start();
        wr_seen = 0;
        rd_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 32'(done), 1);
        check("busy_at_done", 32'(busy), 0);
    endtask

    task automatic check_clean_pass(input string tag, input int passes);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_pass"}, 32'(pass_count), 32'(passes));
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_wq_left"}, wq.size(), 0);
        check({tag, "_rq_left"}, rq.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_pass"}, 32'(pass_count), 0);
        check({tag, "_fe_addr"}, 32'(first_err_addr), 0);
        check({tag, "_fe_exp"}, 32'(first_err_exp), 0);
        check({tag, "_fe_got"}, 32'(first_err_got), 0);
        check({tag, "_req"}, 32'(sram_req), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1);
    end

    int cyc;
    int guard;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        loop  = 1'b0;
        stop  = 1'b0;
        do_reset();
        check_all_zero("reset");

        // Plain single pass, fixed timing.
        push_pass(0);
        do_start();
        wait_done(2000, cyc);
        check_clean_pass("basic", 1);
        check("basic_writes", wr_seen, 16);
        check("basic_reads", rd_seen, 16);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);

        // Stuck-at-1 on bit 3 at addr 5.
        fault_en = 1;
        push_pass(0);
        do_start();
        wait_done(2000, cyc);
        check("fault_err", 32'(err_count), 1);
        check("fault_addr", 32'(first_err_addr), 5);
        check("fault_exp", 32'(first_err_exp), 32'h05);
        check("fault_got", 32'(first_err_got), 32'h0D);
        check("fault_pass", 32'(pass_count), 1);

        // Reset while a read is outstanding, after the error was recorded.
        push_pass(0);
        do_start();
        guard = 0;
        while (rd_seen < 8 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("rd_reached", 32'(rd_seen >= 8), 1);
        do_reset();
        check_all_zero("midreset");
        fault_en = 0;
        push_pass(0);
        do_start();
        wait_done(2000, cyc);
        check_clean_pass("after_reset", 1);

        // Soak loop with a stop request inside pass 3.
        loop = 1'b1;
        push_pass(0);
        push_pass(1);
        push_pass(2);
        do_start();
        guard = 0;
        while (wr_seen < 37 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("pass3_reached", 32'(wr_seen >= 37), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop = 1'b0;
        loop = 1'b1;
        wait_done(5000, cyc);
        loop = 1'b0;
        check_clean_pass("loop", 3);
        check("loop_writes", wr_seen, 48);
        check("loop_reads", rd_seen, 48);

        // Random ack delays and coincident read data.
        rand_mode = 1;
        for (int r = 0; r < 3; r++) begin
            push_pass(0);
            do_start();
            wait_done(20000, cyc);
            check_clean_pass("random", 1);
            check("random_reads", rd_seen, 16);
        end
        rand_mode = 0;

        // Controller never acknowledges.
        never_ack = 1;
        push_pass(0);
        do_start();
        wait_done(1000, cyc);
        check("to_flag", 32'(timeout), 1);
        check("to_req", 32'(sram_req), 0);
        check("to_pass", 32'(pass_count), 0);
        check("to_cycles_in_range", 32'(cyc >= 255 && cyc <= 260), 1);
        never_ack = 0;
        do_reset();
        check("to_cleared_by_reset", 32'(timeout), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
